// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch timekeeping slice: FSM encoding,
// BCD digit width and the active-low seven-segment glyphs ({g,f,e,d,c,b,a}).
package stopwatch_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sw_state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam logic [6:0] SEG_ONE   = 7'b1111001;
    localparam logic [6:0] SEG_TWO   = 7'b0100100;
    localparam logic [6:0] SEG_THREE = 7'b0110000;
    localparam logic [6:0] SEG_FOUR  = 7'b0011001;
    localparam logic [6:0] SEG_FIVE  = 7'b0010010;
    localparam logic [6:0] SEG_SIX   = 7'b0000010;
    localparam logic [6:0] SEG_SEVEN = 7'b1111000;
    localparam logic [6:0] SEG_EIGHT = 7'b0000000;
    localparam logic [6:0] SEG_NINE  = 7'b0010000;

endpackage

// File: rtl/bcd_to_sseg.sv
// Combinational BCD to active-low seven-segment decoder; non-BCD codes blank.
module bcd_to_sseg
    import stopwatch_pkg::*;
(
    input  logic [DIGIT_W-1:0] bcd,
    output logic [6:0]         seg
);

    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_ZERO;
            4'd1:    seg = SEG_ONE;
            4'd2:    seg = SEG_TWO;
            4'd3:    seg = SEG_THREE;
            4'd4:    seg = SEG_FOUR;
            4'd5:    seg = SEG_FIVE;
            4'd6:    seg = SEG_SIX;
            4'd7:    seg = SEG_SEVEN;
            4'd8:    seg = SEG_EIGHT;
            4'd9:    seg = SEG_NINE;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch counting hundredths 00.00..99.99 in BCD with start/stop and clear
// buttons; drives four decoded digits for the downstream scan multiplexer.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start_stop,
    input  logic       btn_clear,
    output logic [6:0] seg0,
    output logic [6:0] seg1,
    output logic [6:0] seg2,
    output logic [6:0] seg3,
    output logic       running,
    output logic       overflow
);

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);

    logic ss_sync1, ss_sync2, ss_sync2_d;
    logic clr_sync1, clr_sync2, clr_sync2_d;
    logic ss_edge, clr_edge;

    sw_state_t          state, state_next;
    logic [PRE_W-1:0]   prescaler, prescaler_next;
    logic [DIGIT_W-1:0] digit      [4];
    logic [DIGIT_W-1:0] digit_next [4];
    logic               tick, carry, wrap;

    assign ss_edge  = ss_sync2 & ~ss_sync2_d;
    assign clr_edge = clr_sync2 & ~clr_sync2_d;

    always_comb begin
        state_next     = state;
        prescaler_next = prescaler;
        digit_next     = digit;
        tick           = 1'b0;
        carry          = 1'b0;
        wrap           = 1'b0;

        // Prescaler only advances in RUN, so a pause keeps the partial tick.
        if (state == RUN) begin
            if (prescaler == PRE_MAX) begin
                prescaler_next = '0;
                tick           = 1'b1;
            end else begin
                prescaler_next = prescaler + 1'b1;
            end
        end

        carry = tick;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (digit[i] == 4'd9) begin
                    digit_next[i] = '0;
                end else begin
                    digit_next[i] = digit[i] + 4'd1;
                    carry         = 1'b0;
                end
            end
        end
        wrap = carry;

        case (state)
            IDLE:    if (ss_edge) state_next = RUN;
            RUN:     if (ss_edge) state_next = PAUSE;
            PAUSE:   if (ss_edge) state_next = RUN;
            default: state_next = IDLE;
        endcase

        // Clear overrides everything, including a coincident tick or start edge.
        if (clr_edge) begin
            state_next     = IDLE;
            prescaler_next = '0;
            for (int i = 0; i < 4; i++) digit_next[i] = '0;
            wrap           = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ss_sync1    <= 1'b0;
            ss_sync2    <= 1'b0;
            ss_sync2_d  <= 1'b0;
            clr_sync1   <= 1'b0;
            clr_sync2   <= 1'b0;
            clr_sync2_d <= 1'b0;
            state       <= IDLE;
            prescaler   <= '0;
            for (int i = 0; i < 4; i++) digit[i] <= '0;
            running     <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            ss_sync1    <= btn_start_stop;
            ss_sync2    <= ss_sync1;
            ss_sync2_d  <= ss_sync2;
            clr_sync1   <= btn_clear;
            clr_sync2   <= clr_sync1;
            clr_sync2_d <= clr_sync2;
            state       <= state_next;
            prescaler   <= prescaler_next;
            digit       <= digit_next;
            running     <= (state == RUN);
            overflow    <= wrap;
        end
    end

    bcd_to_sseg u_dec0 (.bcd(digit[0]), .seg(seg0));
    bcd_to_sseg u_dec1 (.bcd(digit[1]), .seg(seg1));
    bcd_to_sseg u_dec2 (.bcd(digit[2]), .seg(seg2));
    bcd_to_sseg u_dec3 (.bcd(digit[3]), .seg(seg3));

endmodule

// File: doc/stopwatch_core.md
Name: stopwatch_core

Overview:
Timekeeping stage directly upstream of the four-digit seven-segment scan multiplexer. It counts hundredths of a second in BCD, from 00.00 to 99.99, under start/stop and clear button control. It presents four decoded segment patterns, seg0 (hundredths) through seg3 (tens of seconds), for the multiplexer's in0..in3 inputs. The multiplexer lights the decimal point on digit 2, so the display reads SS.hh.

Parameters:
CLK_HZ, 100_000_000, input clock frequency in Hz
TICK_HZ, 100, count rate in Hz; DIV = CLK_HZ/TICK_HZ, which must be an integer >= 2

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
btn_start_stop  input  1  raw, asynchronous, debounced level; each rising edge toggles run/pause
btn_clear  input  1  raw, asynchronous, debounced level; each rising edge returns to zero/idle
seg0  output  7  active-low pattern {g,f,e,d,c,b,a}, hundredths digit
seg1  output  7  active-low pattern, tenths digit
seg2  output  7  active-low pattern, seconds-units digit
seg3  output  7  active-low pattern, seconds-tens digit
running  output  1  high while in RUN
overflow  output  1  one-cycle pulse when the count wraps 99.99 -> 00.00

Behaviour:
- Reset (async): state IDLE; digits 0; prescaler 0; sync flops 0. running=0, overflow=0, seg0..3 = 7'b1000000 (glyph "0").
- Input conditioning, per button:
  - Two-flop synchronizer, then a delayed copy.
  - edge = sync2 & ~sync2_d.
  - A raw rise first sampled at edge k causes the state update at edge k+2.
- FSM states: IDLE, RUN, PAUSE.
  - IDLE + ss_edge -> RUN.
  - RUN + ss_edge -> PAUSE.
  - PAUSE + ss_edge -> RUN.
  - clr_edge in any state -> IDLE: digits 0 and prescaler 0 on the same edge.
  - clr_edge and ss_edge in the same cycle: clear wins, next state IDLE.
  - clr_edge in IDLE: no visible change.
- Prescaler, width clog2(DIV):
  - Increments only in RUN.
  - Holds its value in PAUSE, so partial ticks are preserved.
  - Held at 0 in IDLE.
  - At DIV-1 it wraps to 0 and asserts the internal tick.
- BCD counter, four 4-bit digits d0..d3:
  - On tick, d0 increments.
  - A digit at 9 wraps to 0 and carries into the next digit.
  - Digits never take values 10-15.
  - 99.99 + tick -> 00.00, overflow=1 for exactly that cycle, state stays RUN.
- The first tick after entering RUN from IDLE occurs DIV cycles after the transition edge.
- A tick and a clr_edge on the same edge: clear wins, digits 0, no overflow pulse.
- A tick and an ss_edge (RUN -> PAUSE) on the same edge: the increment is applied and the state becomes PAUSE.
- Outputs:
  - running is registered (state == RUN).
  - seg0..3 are combinational decodes of the registered digits, with zero added latency from a digit change.
  - overflow is registered.
- Decode table, active-low {g..a}: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Any other input gives 1111111 (blank).

Decomposition:
- Shared package stopwatch_pkg:
  - FSM state encoding (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2).
  - SEG_BLANK, SEG_ZERO and digit-glyph constants.
  - BCD digit width constant (4).
- Sub-module bcd_to_sseg: 4-bit BCD in, 7-bit active-low pattern out, purely combinational, instantiated four times.
- Synchronizer and edge-detect logic stays inline.

Test Plan:
All scenarios use CLK_HZ=1000, TICK_HZ=100, so DIV=10.
- Reset mid-count: assert reset asynchronously while showing 03.47 -> seg0..3 all 1000000, running=0 immediately, before any clk edge.
- Start, then run 25 ticks: pulse btn_start_stop -> running rises 3 edges after the input is sampled; after 250 further cycles the digits read 00.25 (seg0=0010010, seg1=0100100).
- Pause preserves partial tick: pause 4 cycles into a tick period, hold 50 cycles, resume -> next increment occurs 6 cycles after resume; digits unchanged during the pause.
- Carry chain: preload via run to 09.99, one more tick -> 10.00 (seg3=1111001, others 1000000), no overflow.
- Wrap: run to 99.99, one tick -> 00.00, overflow high exactly 1 cycle, running stays 1.
- Simultaneous edges: btn_clear and btn_start_stop rise in the same cycle while in RUN at 00.07 -> state IDLE, digits 00.00, running=0; a later lone start edge resumes from 00.00.
